// File: rtl/fir_output_resize.sv
`default_nettype none
// ============================================================================
//  Module   : fir_output_resize
//  Brief    : Output scaler for the configurable FIR. Arithmetic right shift
//             with optional round-half-up, then saturation to signed
//             G_DOUT_WIDTH. Two-stage valid/ready pipeline with a global
//             stall, plus saturation statistics for tap-gain debug.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_output_resize #(
  parameter int G_ACC_WIDTH   = 34,
  parameter int G_DOUT_WIDTH  = 16,
  parameter int G_SHIFT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [G_SHIFT_WIDTH-1:0] shift,
  input  logic                     round_en,
  input  logic [G_ACC_WIDTH-1:0]   din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [G_DOUT_WIDTH-1:0]  dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  input  logic                     clear_stats,
  output logic [15:0]              sat_count,
  output logic                     sat_flag
);

  // Largest shift that still leaves the sign bit in the result.
  localparam logic [G_SHIFT_WIDTH-1:0] c_max_shift = G_SHIFT_WIDTH'(G_ACC_WIDTH - 1);
  localparam logic [G_ACC_WIDTH:0]     c_one       = (G_ACC_WIDTH + 1)'(1);
  // Output range limits expressed in the stage-1 (G_ACC_WIDTH+1 bit) domain.
  localparam logic signed [G_ACC_WIDTH:0] c_sat_max =
    {{(G_ACC_WIDTH - G_DOUT_WIDTH + 2){1'b0}}, {(G_DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [G_ACC_WIDTH:0] c_sat_min =
    {{(G_ACC_WIDTH - G_DOUT_WIDTH + 2){1'b1}}, {(G_DOUT_WIDTH - 1){1'b0}}};

  logic                           s1_valid_q, s1_valid_d;
  logic signed [G_ACC_WIDTH:0]    s1_data_q,  s1_data_d;
  logic                           dout_valid_q, dout_valid_d;
  logic [G_DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic [15:0]                    sat_count_q, sat_count_d;
  logic                           sat_flag_q, sat_flag_d;

  logic                           advance;
  logic [G_SHIFT_WIDTH-1:0]       sh;
  logic [G_ACC_WIDTH:0]           rnd;
  logic signed [G_ACC_WIDTH:0]    din_ext;
  logic signed [G_ACC_WIDTH:0]    sum;
  logic signed [G_ACC_WIDTH:0]    shifted;
  logic                           sat_hi, sat_lo, sat_event;
  logic [G_DOUT_WIDTH-1:0]        sat_value;

  // Scale datapath: clamp the shift, add the rounding half, shift arithmetically.
  always_comb begin
    sh      = (shift > c_max_shift) ? c_max_shift : shift;
    rnd     = (round_en && (sh != '0)) ? (c_one << (sh - G_SHIFT_WIDTH'(1))) : '0;
    din_ext = {din[G_ACC_WIDTH-1], din};
    // One extra bit of headroom so the rounding add can never wrap.
    sum     = din_ext + rnd;
    shifted = sum >>> sh;
  end

  // Saturation of the stage-1 value to the signed output range.
  always_comb begin
    sat_hi    = (s1_data_q > c_sat_max);
    sat_lo    = (s1_data_q < c_sat_min);
    sat_value = s1_data_q[G_DOUT_WIDTH-1:0];
    if (sat_hi) begin
      sat_value = {1'b0, {(G_DOUT_WIDTH - 1){1'b1}}};
    end else if (sat_lo) begin
      sat_value = {1'b1, {(G_DOUT_WIDTH - 1){1'b0}}};
    end
  end

  // Pipeline control and next-state: global stall, flush on enable low.
  always_comb begin
    advance      = enable && !reset && (!dout_valid_q || dout_ready);
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    sat_event    = 1'b0;

    if (!enable) begin
      s1_valid_d   = 1'b0;
      dout_valid_d = 1'b0;
      dout_d       = '0;
    end else if (advance) begin
      s1_valid_d   = din_valid;
      if (din_valid) begin
        s1_data_d  = shifted;
      end
      dout_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dout_d     = sat_value;
        sat_event  = sat_hi || sat_lo;
      end
    end

    // Clear wins over a same-cycle saturation event; the counter sticks at max.
    sat_count_d = sat_count_q;
    sat_flag_d  = sat_flag_q;
    if (clear_stats) begin
      sat_count_d = '0;
      sat_flag_d  = 1'b0;
    end else if (sat_event) begin
      sat_flag_d  = 1'b1;
      if (sat_count_q != 16'hFFFF) begin
        sat_count_d = sat_count_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      sat_count_q  <= '0;
      sat_flag_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      sat_count_q  <= sat_count_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign din_ready  = advance;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat_count  = sat_count_q;
  assign sat_flag   = sat_flag_q;

endmodule
`default_nettype wire

// File: doc/fir_output_resize.md
Name: fir_output_resize

Overview:
Downstream stage of the configurable FIR. Consumes the full-precision signed accumulator result and scales it to output width: programmable arithmetic right shift, optional round-half-up, then saturation to signed G_DOUT_WIDTH. Two-stage pipeline with valid/ready on both sides and saturation statistics for tap-gain debug.

Parameters:
G_ACC_WIDTH, 34, width of signed input accumulator (M_LOG2+G_DATA_WIDTH+G_TAP_WIDTH for default FIR)
G_DOUT_WIDTH, 16, width of signed output sample
G_SHIFT_WIDTH, 6, width of shift control; must satisfy 2**G_SHIFT_WIDTH >= G_ACC_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  0 = flush pipeline, hold din_ready low
shift  in  G_SHIFT_WIDTH  right-shift amount, unsigned, sampled with each accepted din
round_en  in  1  1 = round-half-up before shift, sampled with each accepted din
din  in  G_ACC_WIDTH  signed accumulator value
din_valid  in  1  din qualifier
din_ready  out  1  block can accept din this cycle
dout  out  G_DOUT_WIDTH  signed scaled sample
dout_valid  out  1  dout qualifier
dout_ready  in  1  downstream accepts dout
clear_stats  in  1  single-cycle pulse, clears sat_count and sat_flag
sat_count  out  16  number of saturated outputs, sticks at 0xFFFF
sat_flag  out  1  sticky, set on any saturation

Behaviour:
- Reset (reset=1): s1_valid, dout_valid, sat_flag = 0; dout = 0; sat_count = 0; din_ready = 0.
- enable=0 (reset=0): s1_valid, dout_valid cleared; dout = 0; din_ready = 0; sat_count/sat_flag hold.
- advance = enable && !reset && (!dout_valid || dout_ready); din_ready = advance (combinational). Global stall: both stages hold when advance=0.
- Transfer on din_valid && din_ready; dout transfer on dout_valid && dout_ready.
- Stage 1 (on advance): s1_valid <= din_valid. If din_valid: sh = min(shift, G_ACC_WIDTH-1); if round_en && sh>0, add 2**(sh-1) in G_ACC_WIDTH+1-bit signed (no wrap); arithmetic right shift by sh; register result (G_ACC_WIDTH+1 bits).
- Stage 2 (on advance): dout_valid <= s1_valid. If s1_valid: value > 2**(G_DOUT_WIDTH-1)-1 -> dout = max positive; value < -2**(G_DOUT_WIDTH-1) -> dout = most negative; else dout = low G_DOUT_WIDTH bits. dout holds when not advancing.
- Latency: din accepted in cycle T -> dout_valid=1 from cycle T+2. Throughput 1 sample/cycle without backpressure.
- Stats: saturation event = stage-2 load of a clamped value. Event -> sat_flag <= 1, sat_count increments unless 0xFFFF. clear_stats has priority: same-cycle event dropped, count = 0, flag = 0.
- No data loss or reordering under any dout_ready pattern. din ignored when din_ready=0.
- Reset/enable low mid-stream: in-flight samples discarded, dout_valid=0 next cycle. First din after release -> dout 2 cycles later.
- round_en with sh=0: no rounding add.
- Negative-rounding convention: half rounds toward +inf (-1.5 -> -1).

Test Plan:
1. shift=0, round_en=0, din=100 at cycle T, dout_ready=1 -> dout=100, dout_valid=1 at T+2 for one cycle; sat_count=0.
2. shift=4, round_en=1: din=24 -> 2; din=-24 -> -1. round_en=0: din=24 -> 1; din=-24 -> -2. Back-to-back, 4 outputs in consecutive cycles.
3. shift=0: din=40000 -> 32767, sat_count=1, sat_flag=1; din=-40000 -> -32768, sat_count=2. clear_stats pulse -> sat_count=0, sat_flag=0. clear_stats in same cycle as saturating load -> sat_count=0.
4. Stream din=1,2,3,4 on consecutive cycles, dout_ready=0 for 5 cycles starting when first dout_valid rises -> din_ready=0 while stalled, dout holds 1; after release, outputs 1,2,3,4 in order, none lost or duplicated.
5. shift=40 (clamped to 33): din=-1 -> -1; din=2**33-1 -> 0 (round_en=0) and 1 (round_en=1).
6. Assert reset one cycle after accepting two samples -> dout_valid=0, din_ready=0, sat_count=0 next cycle; deassert, din=7, shift=0 -> dout=7 two cycles later. Repeat with enable=0 -> sat_count preserved.
